// File: rtl/debug_controller_pkg.sv
// Shared definitions for the UART debug controller: command bytes, halt opcode
// and the state encodings of the controller and its word serializer.
package debug_controller_pkg;

  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_CONT = 8'h43;
  localparam logic [7:0] CMD_STEP = 8'h53;

  localparam logic [5:0] HALT_OPCODE = 6'b111111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WRITE,
    ST_RUN,
    ST_STEP,
    ST_DUMP_SETTLE,
    ST_DUMP_LOAD,
    ST_DUMP_WAIT
  } ctrl_state_t;

  typedef enum logic [1:0] {
    PH_PC,
    PH_REG,
    PH_MEM
  } dump_phase_t;

  typedef enum logic [1:0] {
    SER_IDLE,
    SER_SEND,
    SER_WAIT
  } ser_state_t;

endpackage

// File: rtl/debug_controller_if.sv
// UART-side byte handshake between the debug controller and the rx/tx cores.
interface debug_controller_if;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       tx_done;
  logic       tx_start;
  logic [7:0] tx_data;

  modport master (
    input  rx_data,
    input  rx_done,
    input  tx_done,
    output tx_start,
    output tx_data
  );

  modport slave (
    output rx_data,
    output rx_done,
    output tx_done,
    input  tx_start,
    input  tx_data
  );
endinterface

// File: rtl/debug_controller_word_serializer.sv
// Sends one word as N_BYTES bytes, MSB first, one tx_start per tx_done, and
// pulses done together with the tx_done of the final byte.
module word_serializer
  import debug_controller_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int N_BYTES = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic [NB_DATA-1:0] word_in,
  input  logic               tx_done,
  output logic               tx_start,
  output logic [7:0]         tx_data,
  output logic               done
);

  localparam int CW = $clog2(N_BYTES);

  ser_state_t         state;
  ser_state_t         state_next;
  logic [NB_DATA-1:0] shift_reg;
  logic [CW-1:0]      byte_cnt;
  logic               last_byte;

  assign last_byte = (byte_cnt == CW'(N_BYTES - 1));
  assign tx_data   = shift_reg[NB_DATA-1 -: 8];

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= SER_IDLE;
    else       state <= state_next;
  end

  // Next state: one cycle of tx_start, then hold until the byte is acknowledged.
  always_comb begin
    state_next = state;
    tx_start   = 1'b0;
    done       = 1'b0;
    case (state)
      SER_IDLE: if (load) state_next = SER_SEND;
      SER_SEND: begin
        tx_start   = 1'b1;
        state_next = SER_WAIT;
      end
      SER_WAIT: begin
        if (tx_done) begin
          if (last_byte) begin
            done       = 1'b1;
            state_next = SER_IDLE;
          end else begin
            state_next = SER_SEND;
          end
        end
      end
      default: state_next = SER_IDLE;
    endcase
  end

  // Word capture and byte shifting; the top byte is always the one on tx_data.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shift_reg <= '0;
      byte_cnt  <= '0;
    end else if (state == SER_IDLE && load) begin
      shift_reg <= word_in;
      byte_cnt  <= '0;
    end else if (state == SER_WAIT && tx_done) begin
      shift_reg <= shift_reg << 8;
      byte_cnt  <= byte_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/debug_controller.sv
// UART debug sequencer for the pipeline: loads program words, runs or steps the
// pipeline, then dumps PC, registers and a data-memory window back over UART.
module debug_controller
  import debug_controller_pkg::*;
#(
  parameter int NB_DATA     = 32,
  parameter int NB_REG      = 5,
  parameter int NB_ADDR     = 7,
  parameter int N_REGISTER  = 32,
  parameter int N_MEM_WORDS = 32,
  parameter int INST_DEPTH  = 256,
  parameter int N_BYTES     = 4
) (
  input  logic               clock,
  input  logic               reset,
  debug_controller_if.master uart,
  input  logic               halt_signal_o_wb,
  input  logic [NB_DATA-1:0] data_pc_debug,
  input  logic [NB_DATA-1:0] data_registers_debug,
  input  logic [NB_DATA-1:0] data_mem_debug,
  output logic               en_pipeline,
  output logic               en_read_inst,
  output logic [NB_DATA-1:0] data_inst_to_write,
  output logic               ready_instr_to_write,
  output logic [NB_DATA-1:0] o_dir_mem_write,
  output logic               select_debug_or_wireA,
  output logic [NB_REG-1:0]  addr_reg_debug,
  output logic               select_debug_or_alu_result,
  output logic [NB_ADDR-1:0] addr_mem_debug
);

  localparam int BCW      = $clog2(N_BYTES);
  localparam int IW       = $clog2(INST_DEPTH) + 1;
  localparam int DUMP_MAX = (N_REGISTER > N_MEM_WORDS) ? N_REGISTER : N_MEM_WORDS;
  localparam int DW       = $clog2(DUMP_MAX);

  ctrl_state_t        state;
  ctrl_state_t        state_next;
  dump_phase_t        phase;
  logic [NB_DATA-1:0] shift_reg;
  logic [BCW-1:0]     byte_cnt;
  logic [IW-1:0]      inst_idx;
  logic [DW-1:0]      dump_idx;
  logic               halted;
  logic               last_write;
  logic               last_reg;
  logic               last_mem;
  logic               in_dump;
  logic               ser_load;
  logic [NB_DATA-1:0] ser_word;
  logic               ser_done;

  assign last_write = (shift_reg[NB_DATA-1 -: 6] == HALT_OPCODE) ||
                      (inst_idx == IW'(INST_DEPTH - 1));
  assign last_reg   = (dump_idx == DW'(N_REGISTER - 1));
  assign last_mem   = (dump_idx == DW'(N_MEM_WORDS - 1));
  assign in_dump    = (state == ST_DUMP_SETTLE) || (state == ST_DUMP_LOAD) ||
                      (state == ST_DUMP_WAIT);

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Command decode, sequencing and all pipeline-facing outputs.
  always_comb begin
    state_next                 = state;
    en_pipeline                = 1'b0;
    en_read_inst               = 1'b1;
    ready_instr_to_write       = 1'b0;
    data_inst_to_write         = '0;
    o_dir_mem_write            = '0;
    select_debug_or_wireA      = 1'b0;
    addr_reg_debug             = '0;
    select_debug_or_alu_result = 1'b0;
    addr_mem_debug             = '0;
    ser_load                   = 1'b0;
    ser_word                   = data_pc_debug;

    case (state)
      ST_IDLE: begin
        if (uart.rx_done) begin
          case (uart.rx_data)
            CMD_LOAD: state_next = ST_LOAD;
            CMD_CONT: state_next = halted ? ST_DUMP_SETTLE : ST_RUN;
            CMD_STEP: state_next = ST_STEP;
            default:  state_next = ST_IDLE;
          endcase
        end
      end
      ST_LOAD: begin
        en_read_inst = 1'b0;
        if (uart.rx_done && byte_cnt == BCW'(N_BYTES - 1)) state_next = ST_WRITE;
      end
      ST_WRITE: begin
        en_read_inst         = 1'b0;
        ready_instr_to_write = 1'b1;
        data_inst_to_write   = shift_reg;
        o_dir_mem_write      = NB_DATA'(inst_idx);
        state_next           = last_write ? ST_IDLE : ST_LOAD;
      end
      ST_RUN: begin
        en_pipeline = !halt_signal_o_wb;
        if (halt_signal_o_wb) state_next = ST_DUMP_SETTLE;
      end
      ST_STEP: begin
        en_pipeline = !halt_signal_o_wb && !halted;
        state_next  = ST_DUMP_SETTLE;
      end
      ST_DUMP_SETTLE: state_next = ST_DUMP_LOAD;
      ST_DUMP_LOAD: begin
        ser_load   = 1'b1;
        state_next = ST_DUMP_WAIT;
      end
      ST_DUMP_WAIT: begin
        if (ser_done) begin
          state_next = (phase == PH_MEM && last_mem) ? ST_IDLE : ST_DUMP_SETTLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    if (in_dump) begin
      case (phase)
        PH_REG: begin
          select_debug_or_wireA = 1'b1;
          addr_reg_debug        = NB_REG'(dump_idx);
          ser_word              = data_registers_debug;
        end
        PH_MEM: begin
          select_debug_or_alu_result = 1'b1;
          addr_mem_debug             = NB_ADDR'(dump_idx);
          ser_word                   = data_mem_debug;
        end
        default: ser_word = data_pc_debug;
      endcase
    end
  end

  // Load word assembly, instruction index, halted flag and dump position.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shift_reg <= '0;
      byte_cnt  <= '0;
      inst_idx  <= '0;
      halted    <= 1'b0;
      phase     <= PH_PC;
      dump_idx  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (uart.rx_done && uart.rx_data == CMD_LOAD) begin
            halted   <= 1'b0;
            inst_idx <= '0;
            byte_cnt <= '0;
          end
          if (uart.rx_done && (uart.rx_data == CMD_CONT || uart.rx_data == CMD_STEP)) begin
            phase    <= PH_PC;
            dump_idx <= '0;
          end
        end
        ST_LOAD: begin
          if (uart.rx_done) begin
            shift_reg <= {shift_reg[NB_DATA-9:0], uart.rx_data};
            byte_cnt  <= byte_cnt + 1'b1;
          end
        end
        ST_WRITE: begin
          inst_idx <= inst_idx + 1'b1;
          byte_cnt <= '0;
        end
        ST_RUN, ST_STEP: begin
          if (halt_signal_o_wb) halted <= 1'b1;
        end
        ST_DUMP_WAIT: begin
          if (ser_done) begin
            case (phase)
              PH_PC: begin
                phase    <= PH_REG;
                dump_idx <= '0;
              end
              PH_REG: begin
                if (last_reg) begin
                  phase    <= PH_MEM;
                  dump_idx <= '0;
                end else begin
                  dump_idx <= dump_idx + 1'b1;
                end
              end
              default: dump_idx <= last_mem ? '0 : dump_idx + 1'b1;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

  word_serializer #(
    .NB_DATA (NB_DATA),
    .N_BYTES (N_BYTES)
  ) u_serializer (
    .clock    (clock),
    .reset    (reset),
    .load     (ser_load),
    .word_in  (ser_word),
    .tx_done  (uart.tx_done),
    .tx_start (uart.tx_start),
    .tx_data  (uart.tx_data),
    .done     (ser_done)
  );

endmodule

// File: tb/tb_debug_controller.sv
// Directed bench for debug_controller: program load, unknown command, step,
// continuous run to halt, slow UART acknowledge and reset in the middle of a dump.
module tb_debug_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic        halt_signal_o_wb;
  logic [31:0] data_pc_debug;
  logic [31:0] data_registers_debug;
  logic [31:0] data_mem_debug;
  logic        en_pipeline;
  logic        en_read_inst;
  logic [31:0] data_inst_to_write;
  logic        ready_instr_to_write;
  logic [31:0] o_dir_mem_write;
  logic        select_debug_or_wireA;
  logic [4:0]  addr_reg_debug;
  logic        select_debug_or_alu_result;
  logic [6:0]  addr_mem_debug;

  debug_controller_if u_if ();

  debug_controller dut (
    .clock                      (clock),
    .reset                      (reset),
    .uart                       (u_if.master),
    .halt_signal_o_wb           (halt_signal_o_wb),
    .data_pc_debug              (data_pc_debug),
    .data_registers_debug       (data_registers_debug),
    .data_mem_debug             (data_mem_debug),
    .en_pipeline                (en_pipeline),
    .en_read_inst               (en_read_inst),
    .data_inst_to_write         (data_inst_to_write),
    .ready_instr_to_write       (ready_instr_to_write),
    .o_dir_mem_write            (o_dir_mem_write),
    .select_debug_or_wireA      (select_debug_or_wireA),
    .addr_reg_debug             (addr_reg_debug),
    .select_debug_or_alu_result (select_debug_or_alu_result),
    .addr_mem_debug             (addr_mem_debug)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  int          en_cnt      = 0;
  int          overlap_cnt = 0;
  int          reg_sel_cnt = 0;
  int          mem_sel_cnt = 0;
  int          slow_reg    = 0;
  logic [7:0]  tx_q[$];
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];

  int en_base, tx_base, reg_base, mem_base;
  logic [7:0] load_bytes [8];

  // Register file and data memory respond one cycle after the address, like the real pipeline.
  always @(posedge clock) begin
    data_registers_debug <= select_debug_or_wireA ? (32'hC0DE0000 | 32'(addr_reg_debug)) : 32'hBAD0BAD0;
    data_mem_debug       <= select_debug_or_alu_result ? (32'h5EED0000 | 32'(addr_mem_debug)) : 32'hBAD1BAD1;
  end

  // Records enabled pipeline cycles and instruction-memory write strobes.
  always @(negedge clock) begin
    if (en_pipeline) en_cnt++;
    if (ready_instr_to_write) begin
      wr_addr_q.push_back(o_dir_mem_write);
      wr_data_q.push_back(data_inst_to_write);
    end
  end

  // UART transmitter model: takes each tx_start byte and acknowledges it after a delay.
  initial begin
    u_if.tx_done = 1'b0;
    forever begin
      @(negedge clock);
      while (u_if.tx_start === 1'b1) begin
        int dly;
        tx_q.push_back(u_if.tx_data);
        if (select_debug_or_wireA) reg_sel_cnt++;
        if (select_debug_or_alu_result) mem_sel_cnt++;
        dly = (slow_reg != 0 && select_debug_or_wireA) ? 50 : 2;
        repeat (dly) begin
          @(negedge clock);
          if (u_if.tx_start) overlap_cnt++;
        end
        u_if.tx_done = 1'b1;
        @(negedge clock);
        u_if.tx_done = 1'b0;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    @(posedge clock);
    #1;
    u_if.rx_data = b;
    u_if.rx_done = 1'b1;
    @(posedge clock);
    #1;
    u_if.rx_done = 1'b0;
  endtask

  task automatic waitDump(input int base);
    int guard = 0;
    while ((tx_q.size() - base) < 260 && guard < 30000) begin
      @(negedge clock);
      guard++;
    end
    repeat (20) @(negedge clock);
    checkOutput("dump_len", 32'(tx_q.size() - base), 32'd260);
  endtask

  task automatic checkDump(input int base, input logic [31:0] pc);
    for (int k = 0; k < 260; k++) begin
      int w;
      logic [31:0] exp_word;
      logic [31:0] exp_byte;
      logic [31:0] act;
      w = k / 4;
      if (w == 0)       exp_word = pc;
      else if (w <= 32) exp_word = 32'hC0DE0000 | 32'(w - 1);
      else              exp_word = 32'h5EED0000 | 32'(w - 33);
      exp_byte = (exp_word >> (8 * (3 - (k % 4)))) & 32'hFF;
      act = (base + k < tx_q.size()) ? 32'(tx_q[base + k]) : 32'h100;
      checkOutput($sformatf("dump_byte%0d", k), act, exp_byte);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_tx_start"}, 32'(u_if.tx_start), 32'd0);
    checkOutput({tag, "_tx_data"}, 32'(u_if.tx_data), 32'd0);
    checkOutput({tag, "_en_pipeline"}, 32'(en_pipeline), 32'd0);
    checkOutput({tag, "_en_read_inst"}, 32'(en_read_inst), 32'd1);
    checkOutput({tag, "_ready"}, 32'(ready_instr_to_write), 32'd0);
    checkOutput({tag, "_inst_data"}, data_inst_to_write, 32'd0);
    checkOutput({tag, "_dir"}, o_dir_mem_write, 32'd0);
    checkOutput({tag, "_sel_reg"}, 32'(select_debug_or_wireA), 32'd0);
    checkOutput({tag, "_addr_reg"}, 32'(addr_reg_debug), 32'd0);
    checkOutput({tag, "_sel_mem"}, 32'(select_debug_or_alu_result), 32'd0);
    checkOutput({tag, "_addr_mem"}, 32'(addr_mem_debug), 32'd0);
  endtask

  // Hard stop in case the design never returns.
  initial begin
    #900000;
    $display("[TB] FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset            = 1'b1;
    u_if.rx_data     = 8'h00;
    u_if.rx_done     = 1'b0;
    halt_signal_o_wb = 1'b0;
    data_pc_debug    = 32'hA1B2C3D4;
    load_bytes       = '{8'h20, 8'h01, 8'h00, 8'h05, 8'hFC, 8'h00, 8'h00, 8'h00};

    repeat (3) @(posedge clock);
    #1;
    checkResetOutputs("reset");
    @(posedge clock);
    #1;
    reset = 1'b0;

    $display("[TB] unknown command byte");
    en_base = en_cnt;
    tx_base = tx_q.size();
    applyStimulus(8'h41);
    repeat (5) @(posedge clock);
    #1;
    checkOutput("unk_en_read_inst", 32'(en_read_inst), 32'd1);
    checkOutput("unk_tx_bytes", 32'(tx_q.size() - tx_base), 32'd0);
    checkOutput("unk_en_cycles", 32'(en_cnt - en_base), 32'd0);
    checkOutput("unk_writes", 32'(wr_addr_q.size()), 32'd0);

    $display("[TB] program load");
    applyStimulus(8'h4C);
    checkOutput("load_en_read_inst", 32'(en_read_inst), 32'd0);
    for (int i = 0; i < 8; i++) applyStimulus(load_bytes[i]);
    repeat (3) @(posedge clock);
    #1;
    checkOutput("load_writes", 32'(wr_addr_q.size()), 32'd2);
    if (wr_addr_q.size() == 2) begin
      checkOutput("load_addr0", wr_addr_q[0], 32'd0);
      checkOutput("load_data0", wr_data_q[0], 32'h20010005);
      checkOutput("load_addr1", wr_addr_q[1], 32'd1);
      checkOutput("load_data1", wr_data_q[1], 32'hFC000000);
    end
    checkOutput("load_done_en_read_inst", 32'(en_read_inst), 32'd1);

    $display("[TB] single step");
    en_base  = en_cnt;
    tx_base  = tx_q.size();
    reg_base = reg_sel_cnt;
    mem_base = mem_sel_cnt;
    applyStimulus(8'h53);
    waitDump(tx_base);
    checkOutput("step_en_cycles", 32'(en_cnt - en_base), 32'd1);
    checkDump(tx_base, 32'hA1B2C3D4);
    checkOutput("step_reg_sel_bytes", 32'(reg_sel_cnt - reg_base), 32'd128);
    checkOutput("step_mem_sel_bytes", 32'(mem_sel_cnt - mem_base), 32'd128);
    checkOutput("step_overlap", 32'(overlap_cnt), 32'd0);

    $display("[TB] continuous run until halt");
    en_base = en_cnt;
    tx_base = tx_q.size();
    applyStimulus(8'h43);
    repeat (10) @(posedge clock);
    #1;
    halt_signal_o_wb = 1'b1;
    @(posedge clock);
    #1;
    halt_signal_o_wb = 1'b0;
    waitDump(tx_base);
    checkOutput("cont_en_cycles", 32'(en_cnt - en_base), 32'd10);
    checkDump(tx_base, 32'hA1B2C3D4);

    $display("[TB] continuous run while already halted");
    en_base = en_cnt;
    tx_base = tx_q.size();
    applyStimulus(8'h43);
    waitDump(tx_base);
    checkOutput("cont2_en_cycles", 32'(en_cnt - en_base), 32'd0);
    checkDump(tx_base, 32'hA1B2C3D4);

    $display("[TB] step with slow acknowledge in register phase");
    slow_reg = 1;
    en_base  = en_cnt;
    tx_base  = tx_q.size();
    reg_base = reg_sel_cnt;
    applyStimulus(8'h53);
    waitDump(tx_base);
    slow_reg = 0;
    checkOutput("slow_en_cycles", 32'(en_cnt - en_base), 32'd0);
    checkDump(tx_base, 32'hA1B2C3D4);
    checkOutput("slow_reg_sel_bytes", 32'(reg_sel_cnt - reg_base), 32'd128);
    checkOutput("slow_overlap", 32'(overlap_cnt), 32'd0);

    $display("[TB] reset in the middle of a dump");
    tx_base = tx_q.size();
    applyStimulus(8'h53);
    for (int g = 0; g < 5000 && (tx_q.size() - tx_base) < 100; g++) @(negedge clock);
    checkOutput("mid_reached_100", 32'((tx_q.size() - tx_base) >= 100), 32'd1);
    reset = 1'b1;
    #1;
    checkResetOutputs("mid_reset");
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (20) @(posedge clock);
    #1;
    checkOutput("mid_idle_tx_start", 32'(u_if.tx_start), 32'd0);
    data_pc_debug = 32'h00000040;
    en_base = en_cnt;
    tx_base = tx_q.size();
    applyStimulus(8'h53);
    waitDump(tx_base);
    checkOutput("mid_step_en_cycles", 32'(en_cnt - en_base), 32'd1);
    checkDump(tx_base, 32'h00000040);
    checkOutput("final_overlap", 32'(overlap_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
